// File: rtl/pulse_width_rx.sv
// ----------------------------------------------------------------------------
// pulse_width_rx
//   Measures the width, in clk cycles, of each high pulse on din and presents
//   it through a one-entry valid/ready result register. Includes an optional
//   input synchroniser, rejection of pulses shorter than MIN_LEN, saturation
//   of the width counter and a sticky overrun flag for dropped results.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   din      in   pulse line under measurement
//   m_width  out  measured width of the held result
//   m_sat    out  held result saturated (width reached 2**CNT_W-1)
//   m_valid  out  result held and valid
//   m_ready  in   consumer accepts when m_valid && m_ready at posedge
//   overrun  out  sticky: a completed pulse was dropped (register full)
//   clr_ovr  in   synchronous clear of overrun
//   busy     out  high while a pulse is being measured
// ----------------------------------------------------------------------------
module pulse_width_rx #(
    parameter int CNT_W       = 8,
    parameter int MIN_LEN     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [CNT_W-1:0] m_width,
    output logic             m_sat,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             busy
);

    localparam logic [1:0] ST_ARM  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // A minimum length of zero behaves like one: every pulse is at least 1.
    localparam int unsigned MIN_EFF = (MIN_LEN < 1) ? 32'd1 : 32'(MIN_LEN);

    logic s;

    // ------------------------------------------------------------------------
    // Input synchroniser. Flops reset to 1 so a line already high out of reset
    // never looks like a rising edge.
    // ------------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = din;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            assign sync_d[0] = din;
            for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
                assign sync_d[gi] = sync_q[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '1;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_new;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_new = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_MEAS;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_MEAS: begin
                if (s) begin
                    // Saturate rather than wrap so long pulses stay reportable.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    res_new = (32'(cnt_q) >= MIN_EFF);
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // One-entry result register with overrun detection
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] width_q, width_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             drop;

    always_comb begin
        width_d = width_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        drop    = 1'b0;

        if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end

        // A new result may load when the register is empty or being emptied
        // in this same cycle; otherwise it is lost.
        if (res_new) begin
            if (!valid_q || m_ready) begin
                width_d = cnt_q;
                sat_d   = (cnt_q == CNT_MAX);
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        // Set has priority over clear so a drop is never hidden.
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
            width_q <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign m_width = width_q;
    assign m_sat   = sat_q;
    assign m_valid = valid_q;
    assign overrun = ovr_q;
    assign busy    = (state_q == ST_MEAS);

endmodule

// File: tb/tb_pulse_width_rx.sv
// ----------------------------------------------------------------------------
// tb_pulse_width_rx
//   Self-checking bench for pulse_width_rx (CNT_W=8, MIN_LEN=2, SYNC_STAGES=2).
//   Expected results are queued when a pulse is driven and compared when the
//   DUT hands a result over (m_valid && m_ready).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_width_rx;

    localparam int CNT_W = 8;
    localparam int MAXW  = (1 << CNT_W) - 1;
    localparam int MINL  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             din;
    logic [CNT_W-1:0] m_width;
    logic             m_sat;
    logic             m_valid;
    logic             m_ready;
    logic             overrun;
    logic             clr_ovr;
    logic             busy;

    typedef struct {
        int w;
        int sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pulse_width_rx #(
        .CNT_W      (CNT_W),
        .MIN_LEN    (MINL),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .m_width(m_width),
        .m_sat  (m_sat),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .overrun(overrun),
        .clr_ovr(clr_ovr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a pulse of w high samples followed by gap low samples. The
    // expected result is queued unless the caller knows it will be dropped.
    task automatic pulse(input int w, input int gap, input bit expect_out);
        exp_t e;
        if (expect_out && w >= MINL) begin
            e.w   = (w > MAXW) ? MAXW : w;
            e.sat = (w >= MAXW) ? 1 : 0;
            exp_q.push_back(e);
        end
        din = 1'b1;
        repeat (w) step();
        din = 1'b0;
        repeat (gap) step();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        step();
        check(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: compare every accepted result against the queue head.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", int'(m_width), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("result width=%0d sat=%0d (expected %0d/%0d)", m_width, m_sat, e.w, e.sat);
                check("width", int'(m_width), e.w);
                check("sat", int'(m_sat), e.sat);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        din     = 1'b1;
        m_ready = 1'b1;
        clr_ovr = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_width", int'(m_width), 0);
        check("rst_sat", int'(m_sat), 0);
        check("rst_valid", int'(m_valid), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);

        // T1: line high through and after reset is not a pulse
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t1_valid", int'(m_valid), 0);
            check("t1_busy", int'(busy), 0);
        end
        din = 1'b0;
        repeat (5) step();
        check("t1_valid_after", int'(m_valid), 0);
        check("t1_busy_after", int'(busy), 0);

        // T2: 6-cycle pulse, latency SYNC_STAGES+1 from first low sample
        begin
            exp_t e;
            e.w = 6;
            e.sat = 0;
            exp_q.push_back(e);
        end
        din = 1'b1;
        repeat (6) step();
        check("t2_busy", int'(busy), 1);
        din = 1'b0;
        step();
        check("t2_valid_p1", int'(m_valid), 0);
        step();
        check("t2_valid_p2", int'(m_valid), 0);
        step();
        check("t2_valid_p3", int'(m_valid), 1);
        check("t2_width", int'(m_width), 6);
        check("t2_sat", int'(m_sat), 0);
        step();
        check("t2_valid_gone", int'(m_valid), 0);
        check("t2_width_hold", int'(m_width), 6);
        wait_drain("t2_drain");

        // T3: below MIN_LEN discarded, MIN_LEN accepted
        pulse(1, 6, 1'b1);
        check("t3_no_result", int'(m_valid), 0);
        pulse(2, 6, 1'b1);
        wait_drain("t3_drain");

        // T4: saturation then normal pulse
        pulse(300, 6, 1'b1);
        pulse(4, 6, 1'b1);
        wait_drain("t4_drain");
        check("t4_ovr", int'(overrun), 0);

        // T5: held result, second pulse dropped, overrun set then cleared
        m_ready = 1'b0;
        pulse(4, 4, 1'b1);
        pulse(7, 6, 1'b0);
        check("t5_valid_held", int'(m_valid), 1);
        check("t5_width_held", int'(m_width), 4);
        check("t5_ovr", int'(overrun), 1);
        m_ready = 1'b1;
        wait_drain("t5_drain");
        repeat (4) step();
        check("t5_valid_after", int'(m_valid), 0);
        check("t5_ovr_sticky", int'(overrun), 1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("t5_ovr_clr", int'(overrun), 0);

        // T6: back-to-back pulses with a single low cycle between them
        pulse(3, 1, 1'b1);
        pulse(5, 1, 1'b1);
        pulse(2, 6, 1'b1);
        wait_drain("t6_drain");
        check("t6_ovr", int'(overrun), 0);

        // Reset mid-pulse discards the partial measurement
        din = 1'b1;
        repeat (5) step();
        check("t6_busy_mid", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_width", int'(m_width), 0);
        check("t6_rst_valid", int'(m_valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_ovr", int'(overrun), 0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_arm_busy", int'(busy), 0);
        end
        din = 1'b0;
        repeat (4) step();
        pulse(3, 6, 1'b1);
        wait_drain("t6_final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
